// File: rtl/apb_reg_arbiter.sv
// Two-requester round-robin front end for a single APB master; one transfer in flight at a time.
// Optional macro APB_ARB_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT_CYCLES cycles and returns err=1.
module apb_reg_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  RegClk,
  input  logic                  RegResetN,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [31:0]           req0_wdata,
  output logic                  rsp0_valid,
  output logic [31:0]           rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [31:0]           req1_wdata,
  output logic                  rsp1_valid,
  output logic [31:0]           rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state;
  logic        gnt_id;
  logic        any_req;
  logic        pick1;
  logic        xfer_done;
  logic [31:0] done_rdata;
  logic        done_err;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // gnt_id holds the last grant while idle, so a tie goes to the other requester
  always_comb begin
    any_req = req0_valid | req1_valid;
    pick1   = (req0_valid & req1_valid) ? ~gnt_id : req1_valid;
  end

  assign req0_ready = RegResetN & (state == IDLE) & any_req & ~pick1;
  assign req1_ready = RegResetN & (state == IDLE) & any_req &  pick1;

  always_comb begin
    xfer_done  = 1'b0;
    done_rdata = 32'd0;
    done_err   = 1'b0;
    if (state == ACCESS) begin
      if (PREADY) begin
        xfer_done  = 1'b1;
        done_rdata = PWRITE ? 32'd0 : PRDATA;
        done_err   = PSLVERR;
      end
`ifdef APB_ARB_TIMEOUT_EN
      else if (tmo_hit) begin
        xfer_done = 1'b1;
        done_err  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge RegClk or negedge RegResetN) begin
    if (!RegResetN) begin
      state      <= IDLE;
      gnt_id     <= 1'b1;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= 32'd0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= 32'd0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= 32'd0;
      rsp1_err   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id <= pick1;
            PWRITE <= pick1 ? req1_write : req0_write;
            PADDR  <= pick1 ? req1_addr  : req0_addr;
            PWDATA <= pick1 ? req1_wdata : req0_wdata;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (xfer_done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= RESP;
            if (gnt_id) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= done_rdata;
              rsp1_err   <= done_err;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= done_rdata;
              rsp0_err   <= done_err;
            end
          end
`ifdef APB_ARB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// Bench for apb_reg_arbiter: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_apb_reg_arbiter;
  localparam int AW  = 8;
  localparam int TMO = 16;

  logic          RegClk = 1'b0;
  logic          RegResetN;
  logic          req0_valid, req0_ready, req0_write, rsp0_valid, rsp0_err;
  logic [AW-1:0] req0_addr;
  logic [31:0]   req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_ready, req1_write, rsp1_valid, rsp1_err;
  logic [AW-1:0] req1_addr;
  logic [31:0]   req1_wdata, rsp1_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;

  always #5 RegClk = ~RegClk;

  apb_reg_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .RegClk(RegClk), .RegResetN(RegResetN),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct { int id; bit wr; logic [7:0] ad; logic [31:0] wd; } req_t;
  req_t        rq_q[$];
  int          w_q[$];
  int          n_pass, n_chk, cyc;
  bit          rnd_mode;
  // in-flight transaction as the model sees it: accept cycle and derived timeline
  bit          act, tid, t_wr, t_stuck, e_err, last;
  int          t_acc, acc_end, rsp_at;
  logic [7:0]  t_ad;
  logic [31:0] t_wd, e_rd;
  // requester state: 0 idle, 1 request pending, 2 waiting for response
  int          rq_st[2];
  bit          rq_wr[2];
  logic [7:0]  rq_ad[2];
  logic [31:0] rq_wd[2];
  logic [31:0] last_rd[2];
  bit          last_er[2];
  logic [31:0] ref_mem[256];
  logic [31:0] slave_mem[256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, got, exp_v);
  endtask

  task automatic push_req(input int id, input bit wr, input logic [7:0] ad,
                          input logic [31:0] wd, input int w);
    req_t r;
    r.id = id; r.wr = wr; r.ad = ad; r.wd = wd;
    rq_q.push_back(r);
    w_q.push_back(w);
  endtask

  task automatic model_reset();
    act  = 1'b0;
    last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rq_st[i] == 2) rq_st[i] = 0;
      last_rd[i] = 32'd0;
      last_er[i] = 1'b0;
    end
  endtask

  task automatic drive();
    int k;
    for (int i = 0; i < 2; i++) begin
      if (rq_st[i] == 1) begin
        if (rnd_mode && $urandom_range(0, 15) == 0) rq_st[i] = 0;
      end else if (rq_st[i] == 0) begin
        k = -1;
        for (int j = 0; j < rq_q.size(); j++)
          if (rq_q[j].id == i && k < 0) k = j;
        if (k >= 0) begin
          rq_wr[i] = rq_q[k].wr; rq_ad[i] = rq_q[k].ad; rq_wd[i] = rq_q[k].wd;
          rq_q.delete(k);
          rq_st[i] = 1;
        end else if (rnd_mode && $urandom_range(0, 1) == 1) begin
          rq_wr[i] = 1'($urandom);
          rq_ad[i] = 8'(4 * $urandom_range(0, 5));
          rq_wd[i] = $urandom;
          rq_st[i] = 1;
        end
      end else begin
        rq_wr[i] = 1'($urandom); rq_ad[i] = 8'($urandom); rq_wd[i] = $urandom;
      end
    end
    req0_valid = (rq_st[0] == 1); req0_write = rq_wr[0]; req0_addr = rq_ad[0]; req0_wdata = rq_wd[0];
    req1_valid = (rq_st[1] == 1); req1_write = rq_wr[1]; req1_addr = rq_ad[1]; req1_wdata = rq_wd[1];
    PREADY  = act && !t_stuck && (cyc == acc_end);
    PSLVERR = PREADY ? (PADDR[7:4] == 4'h1) : 1'($urandom);
    PRDATA  = PWRITE ? $urandom : slave_mem[PADDR];
  endtask

  task automatic check_cycle();
    bit g, v0, v1, ep, en;
    int w;
    if (act && cyc > rsp_at) act = 1'b0;
    ep = act && cyc >= t_acc + 1 && cyc <= acc_end;
    en = act && cyc >= t_acc + 2 && cyc <= acc_end;
    chk("psel", 32'(PSEL), 32'(ep));
    chk("penable", 32'(PENABLE), 32'(en));
    if (ep) begin
      chk("paddr", 32'(PADDR), 32'(t_ad));
      chk("pwrite", 32'(PWRITE), 32'(t_wr));
      chk("pwdata", PWDATA, t_wd);
    end
    if (act && cyc == rsp_at) begin
      last_rd[tid] = e_rd; last_er[tid] = e_err; rq_st[tid] = 0;
    end
    chk("rsp0_valid", 32'(rsp0_valid), 32'(act && cyc == rsp_at && !tid));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(act && cyc == rsp_at && tid));
    chk("rsp0_rdata", rsp0_rdata, last_rd[0]);
    chk("rsp0_err", 32'(rsp0_err), 32'(last_er[0]));
    chk("rsp1_rdata", rsp1_rdata, last_rd[1]);
    chk("rsp1_err", 32'(rsp1_err), 32'(last_er[1]));
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) slave_mem[PADDR] = PWDATA;
    v0 = req0_valid; v1 = req1_valid;
    if (!act && (v0 || v1)) begin
      g = (v0 && v1) ? !last : v1;
      chk("req0_ready", 32'(req0_ready), 32'(!g));
      chk("req1_ready", 32'(req1_ready), 32'(g));
      act = 1'b1; tid = g; last = g; t_acc = cyc;
      t_wr = rq_wr[g]; t_ad = rq_ad[g]; t_wd = rq_wd[g]; rq_st[g] = 2;
      if (w_q.size() > 0) w = w_q.pop_front();
      else w = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2);
      t_stuck = (w < 0);
      if (t_stuck) w = TMO - 1;
      acc_end = cyc + 2 + w;
      rsp_at  = acc_end + 1;
      if (t_stuck) begin
        e_err = 1'b1; e_rd = 32'd0;
      end else begin
        e_err = (t_ad[7:4] == 4'h1);
        e_rd  = t_wr ? 32'd0 : ref_mem[t_ad];
        if (t_wr && !e_err) ref_mem[t_ad] = t_wd;
      end
    end else begin
      chk("req0_ready", 32'(req0_ready), 32'd0);
      chk("req1_ready", 32'(req1_ready), 32'd0);
    end
  endtask

  task automatic step();
    @(negedge RegClk);
    check_cycle();
    @(posedge RegClk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = !act && rq_q.size() == 0 && rq_st[0] == 0 && rq_st[1] == 0;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic mid_reset();
    RegResetN = 1'b0;
    #1;
    chk("mrst_psel", 32'(PSEL), 32'd0);
    chk("mrst_penable", 32'(PENABLE), 32'd0);
    chk("mrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("mrst_req0_ready", 32'(req0_ready), 32'd0);
    @(negedge RegClk);
    chk("mrst_rsp0_hold", 32'(rsp0_valid), 32'd0);
    @(posedge RegClk);
    #1;
    RegResetN = 1'b1;
    model_reset();
    cyc++;
    drive();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit reached;
    n_pass = 0; n_chk = 0; cyc = 0; rnd_mode = 1'b0; act = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = {24'hA5A5A5, 8'(i)};
      slave_mem[i] = {24'hA5A5A5, 8'(i)};
    end
    for (int i = 0; i < 2; i++) begin
      rq_st[i] = 0; rq_wr[i] = 1'b0; rq_ad[i] = 8'h0; rq_wd[i] = 32'd0;
    end
    RegResetN = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h3C; req0_wdata = 32'h11223344;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h20; req1_wdata = 32'h55667788;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hDEADBEEF;
    repeat (2) @(posedge RegClk);
    @(negedge RegClk);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_rdata", rsp0_rdata, 32'd0);
    chk("rst_rsp1_err", 32'(rsp1_err), 32'd0);
    @(posedge RegClk);
    #1;
    RegResetN = 1'b1;
    model_reset();
    // simultaneous requests straight after reset: requester 0 must win the first tie
    push_req(0, 1'b0, 8'h00, 32'd0, 0);
    push_req(1, 1'b0, 8'h04, 32'd0, 0);
    push_req(0, 1'b0, 8'h00, 32'd0, 0);
    push_req(1, 1'b0, 8'h04, 32'd0, 0);
    cyc++;
    drive();
    drain("drain_rr");

    push_req(0, 1'b1, 8'h0C, 32'hCAFE0001, 0);
    push_req(0, 1'b0, 8'h0C, 32'd0, 0);
    drain("drain_wr_rd");
    chk("readback_0c", rsp0_rdata, 32'hCAFE0001);

    push_req(1, 1'b0, 8'h10, 32'd0, 0);
    drain("drain_slverr");
    chk("slverr_rsp1_err", 32'(rsp1_err), 32'd1);

    push_req(0, 1'b1, 8'h08, 32'h12345678, 5);
    push_req(0, 1'b0, 8'h08, 32'd0, 0);
    drain("drain_wait5");
    chk("wait5_readback", rsp0_rdata, 32'h12345678);

`ifdef APB_ARB_TIMEOUT_EN
    push_req(1, 1'b0, 8'h04, 32'd0, -1);
    drain("drain_timeout");
    chk("timeout_err", 32'(rsp1_err), 32'd1);
`endif

    push_req(0, 1'b0, 8'h00, 32'd0, 4);
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      step();
      reached = act && cyc == t_acc + 3;
    end
    chk("reach_access", 32'(reached), 32'd1);
    mid_reset();
    push_req(0, 1'b0, 8'h0C, 32'd0, 0);
    drain("drain_after_reset");
    chk("post_reset_read", rsp0_rdata, 32'hCAFE0001);

    rnd_mode = 1'b1;
    run(600);
    rnd_mode = 1'b0;
    drain("drain_random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
